// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared constants, state encoding and helpers for the fetch stage
package instr_fetch_unit_pkg;

  // Default fetch parameters
  localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IFU_PC_STEP  = 32'd4;

  // Instruction field bit positions
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;

  // Fetch FSM states
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  // Force a target address onto a word boundary
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// rtl/instr_fetch_unit_pc_reg.sv - program counter with sequential adder and redirect mux
module instr_fetch_unit_pc_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter logic [31:0] PC_STEP  = IFU_PC_STEP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_seq_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // 32-bit add wraps 0xFFFF_FFFC -> 0 naturally
  assign pc_seq_o = pc_q + PC_STEP;
  assign pc_o     = pc_q;

  // Redirect beats sequential advance; targets are forced word-aligned
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = align_pc(redirect_pc_i);
    end else if (advance_i) begin
      pc_d = pc_seq_o;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, single-outstanding imem read, IF/ID slot and field split
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter logic [31:0] PC_STEP  = IFU_PC_STEP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic        misalign
);

  fetch_state_e state_q;
  logic         if_valid_q;
  logic [31:0]  if_instr_q;
  logic [31:0]  if_pc_q;
  logic [31:0]  if_pc_plus4_q;
  logic         misalign_q;

  logic [31:0]  pc;
  logic [31:0]  pc_seq;
  logic         slot_blocked;
  logic         req_raw;
  logic         capture;

  // Slot full and decode not draining it: nothing new may land
  assign slot_blocked = if_valid_q && id_stall;

  // Request is driven by the state; S_REQ withholds it while the slot is blocked
  always_comb begin
    req_raw = 1'b0;
    case (state_q)
      S_REQ:           req_raw = !slot_blocked;
      S_WAIT, S_DROP:  req_raw = 1'b1;
      default:         req_raw = 1'b0;
    endcase
  end

  assign imem_req  = rst_n & req_raw;
  assign imem_addr = pc;

  // A live (non-squashed) response lands in the slot; S_WAIT only follows a free slot
  assign capture = imem_ready && !redirect &&
                   ((state_q == S_REQ && !slot_blocked) || state_q == S_WAIT);

  instr_fetch_unit_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .advance_i     (capture),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .pc_o          (pc),
    .pc_seq_o      (pc_seq)
  );

  // Fetch FSM, IF/ID slot and misalign pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      if_valid_q    <= 1'b0;
      if_instr_q    <= 32'd0;
      if_pc_q       <= 32'd0;
      if_pc_plus4_q <= 32'd0;
      misalign_q    <= 1'b0;
    end else begin
      misalign_q <= redirect && (redirect_pc[1:0] != 2'b00);
      if (redirect) begin
        // Squash the slot; an unanswered request must still be drained
        if_valid_q <= 1'b0;
        state_q    <= (req_raw && !imem_ready) ? S_DROP : S_REQ;
      end else begin
        if (capture) begin
          if_valid_q    <= 1'b1;
          if_instr_q    <= imem_rdata;
          if_pc_q       <= pc;
          if_pc_plus4_q <= pc_seq;
        end else if (!id_stall) begin
          if_valid_q <= 1'b0;
        end
        case (state_q)
          S_REQ: begin
            if (slot_blocked) begin
              state_q <= S_HOLD;
            end else if (!imem_ready) begin
              state_q <= S_WAIT;
            end
          end
          S_WAIT: if (imem_ready) state_q <= S_REQ;
          S_HOLD: if (!id_stall) state_q <= S_REQ;
          S_DROP: if (imem_ready) state_q <= S_REQ;
          default: state_q <= S_REQ;
        endcase
      end
    end
  end

  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_plus4_q;
  assign misalign    = misalign_q;

  assign opcode = if_instr_q[OPCODE_HI:OPCODE_LO];
  assign rs     = if_instr_q[RS_HI:RS_LO];
  assign rt     = if_instr_q[RT_HI:RT_LO];
  assign rd     = if_instr_q[RD_HI:RD_LO];
  assign shamt  = if_instr_q[SHAMT_HI:SHAMT_LO];
  assign funct  = if_instr_q[FUNCT_HI:FUNCT_LO];
  assign imm16  = if_instr_q[IMM_HI:IMM_LO];

endmodule
